signal_sequencer: RTL

SIGNAL_SEQUENCER -- requirements
Module: signal_sequencer

---
 rtl/signal_sequencer_pkg.sv | 45 ++++
 rtl/signal_sequencer_table.sv | 29 ++
 rtl/signal_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/signal_sequencer_pkg.sv
// Shared definitions for the segment sequencer: waveform type codes, FSM encoding
// and the bit layout of a segment configuration word.
package signal_sequencer_pkg;

  localparam logic [3:0] SIG_TRAPEZOID = 4'd1;
  localparam logic [3:0] SIG_TRIANGLE  = 4'd2;
  localparam logic [3:0] SIG_SAWTOOTH  = 4'd3;

  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 4;
  localparam int AMP_LSB  = 4;
  localparam int AMP_W    = 16;
  localparam int PINC_LSB = 20;
  localparam int PINC_W   = 16;
  localparam int REPS_LSB = 36;
  localparam int REPS_W   = 16;
  localparam int LAST_BIT = 52;
  localparam int ENTRY_W  = 53;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic              last;
    logic [REPS_W-1:0] reps;
    logic [PINC_W-1:0] phase_inc;
    logic [AMP_W-1:0]  amplitude;
    logic [TYPE_W-1:0] sig_type;
  } seg_entry_t;

  function automatic seg_entry_t decode_word(input logic [ENTRY_W-1:0] word);
    seg_entry_t e;
    e.sig_type  = word[TYPE_LSB +: TYPE_W];
    e.amplitude = word[AMP_LSB +: AMP_W];
    e.phase_inc = word[PINC_LSB +: PINC_W];
    e.reps      = word[REPS_LSB +: REPS_W];
    e.last      = word[LAST_BIT];
    return e;
  endfunction

endpackage

// File: rtl/signal_sequencer_table.sv
// Segment table: single write port, one registered read port (read returns old data
// when the same entry is written on the same edge).
module seq_table_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 53
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array has no reset, so it maps onto block RAM and a
  // sequencer reset keeps the programmed table.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/signal_sequencer.sv
// Steps a waveform generator through a table of segments, each repeated for a
// programmed number of generator periods; start presented after edge N gives gen_enable after N+2.
module signal_sequencer
  import signal_sequencer_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AMP_WIDTH   = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int REP_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [63:0]              cfg_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     period_wrap,
  output logic [3:0]               gen_type,
  output logic [AMP_WIDTH-1:0]     gen_amplitude,
  output logic [PHASE_WIDTH-1:0]   gen_phase_inc,
  output logic                     gen_enable,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] seg_index,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_e                 state_q;
  logic [ADDR_W-1:0]      seg_q;
  logic [REP_WIDTH-1:0]   rep_q;
  logic                   last_q;
  logic                   stop_pending_q;
  logic [3:0]             type_q;
  logic [AMP_WIDTH-1:0]   amp_q;
  logic [PHASE_WIDTH-1:0] inc_q;
  logic                   gen_enable_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   cfg_err_q;

  logic [ADDR_W-1:0]  rd_addr_d;
  logic [ENTRY_W-1:0] rd_data;
  seg_entry_t         rd_entry;
  logic               table_end;
  logic               unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data[63:ENTRY_W];

  seq_table_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_table (
    .clk     (clk),
    .we_i    (cfg_we && (state_q == ST_IDLE)),
    .waddr_i (cfg_addr),
    .wdata_i (decode_word(cfg_data[ENTRY_W-1:0])),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data)
  );

  assign rd_entry  = seg_entry_t'(rd_data);
  assign table_end = last_q || (seg_q == ADDR_W'(DEPTH - 1));

  // The read is registered, so the address of the entry LOAD will need is
  // presented one cycle ahead: entry 0 from IDLE, the successor while running.
  always_comb begin
    rd_addr_d = seg_q;
    unique case (state_q)
      ST_IDLE: rd_addr_d = '0;
      ST_RUN:  rd_addr_d = table_end ? '0 : seg_q + ADDR_W'(1);
      default: rd_addr_d = seg_q;
    endcase
  end

  // NOTE: reset is synchronous to match the rest of the codebase; every state
  // register sits inside the clocked branch and uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      seg_q          <= '0;
      rep_q          <= '0;
      last_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      type_q         <= '0;
      amp_q          <= '0;
      inc_q          <= '0;
      gen_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= cfg_we && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_q <= ST_LOAD;
            seg_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          type_q       <= rd_entry.sig_type;
          amp_q        <= AMP_WIDTH'(rd_entry.amplitude);
          inc_q        <= PHASE_WIDTH'(rd_entry.phase_inc);
          rep_q        <= (rd_entry.reps == '0) ? REP_WIDTH'(1) : REP_WIDTH'(rd_entry.reps);
          last_q       <= rd_entry.last;
          gen_enable_q <= 1'b1;
          state_q      <= ST_RUN;
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
          if (period_wrap) begin
            if (stop_pending_q || (rep_q == REP_WIDTH'(1) && table_end && !loop_en)) begin
              state_q      <= ST_DRAIN;
              gen_enable_q <= 1'b0;
              amp_q        <= '0;
              done_q       <= 1'b1;
            end else if (rep_q == REP_WIDTH'(1)) begin
              state_q <= ST_LOAD;
              seg_q   <= table_end ? '0 : seg_q + ADDR_W'(1);
            end else begin
              rep_q <= rep_q - REP_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          state_q        <= ST_IDLE;
          busy_q         <= 1'b0;
          stop_pending_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gen_type      = type_q;
  assign gen_amplitude = amp_q;
  assign gen_phase_inc = inc_q;
  assign gen_enable    = gen_enable_q;
  assign busy          = busy_q;
  assign seg_index     = seg_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule
